bot_wb_regfile: RTL and testbench

- Parametrised Wishbone slave register file serving NUM_BOTS Rojobot channels through one bus port.
- Replaces per-bot duplicated slave logic in the Rojobot controller.
- Provides toggle-based CDC of bot status from bot_clk to clk, and sticky update-pending and overrun flags with write-1-to-clear acknowledge.
- Provides a maskable aggregated interrupt, and motor control registers synchronised back into bot_clk.

---
 rtl/bot_wb_if.sv | 23 ++
 rtl/bot_wb_regfile.sv | 117 +++++++++++
 tb/tb_bot_wb_regfile.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bot_wb_if.sv
// bot_wb_if: Wishbone bus bundle between the Rojobot controller and its register file.
interface bot_wb_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_rty_o;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );
endinterface

// File: rtl/bot_wb_regfile.sv
// bot_wb_regfile: Wishbone register file for NUM_BOTS Rojobots with status CDC, sticky flags and IRQ.
module bot_wb_regfile #(
    parameter int NUM_BOTS    = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  bot_clk,
    bot_wb_if.slave               wb,
    input  logic [32*NUM_BOTS-1:0] bot_info_i,
    input  logic [NUM_BOTS-1:0]   bot_upd_i,
    output logic [8*NUM_BOTS-1:0] motctl_o,
    output logic                  irq_o
);
    logic [SYNC_STAGES-1:0]                 brst_q;
    logic                                   bot_rstn;
    logic [NUM_BOTS-1:0][31:0]              hold_q, shadow_q;
    logic [NUM_BOTS-1:0][7:0]               ctrl_q;
    logic [SYNC_STAGES-1:0][NUM_BOTS-1:0]   tsync_q;
    logic [SYNC_STAGES-1:0][8*NUM_BOTS-1:0] msync_q;
    logic [NUM_BOTS-1:0] tog_q, tedge_q, upd_evt, pend_q, pend_d, ovr_q, ovr_d, irq_en_q;
    logic [NUM_BOTS-1:0] hit, ack0, ack1, ctrl_we;
    logic [31:0]         dat_q, rd_d;
    logic                ack_q, irq_q, req, wr, glob, en_we;
    logic [4:0]          off;
    logic                unused_ok;

    // bot_clk reset: asserts with rstn, releases after SYNC_STAGES bot_clk edges
    always_ff @(posedge bot_clk or negedge rstn)
        if (!rstn) brst_q <= '0;
        else       brst_q <= {brst_q[SYNC_STAGES-2:0], 1'b1};

    assign bot_rstn = brst_q[SYNC_STAGES-1];

    always_ff @(posedge bot_clk or negedge bot_rstn)
        if (!bot_rstn) begin
            hold_q  <= '0;
            tog_q   <= '0;
            msync_q <= '0;
        end else begin
            for (int k = 0; k < NUM_BOTS; k++)
                if (bot_upd_i[k]) begin
                    hold_q[k] <= bot_info_i[32*k +: 32];
                    tog_q[k]  <= ~tog_q[k];
                end
            msync_q <= {msync_q[SYNC_STAGES-2:0], ctrl_q};
        end

    assign motctl_o = msync_q[SYNC_STAGES-1];
    assign upd_evt  = tsync_q[SYNC_STAGES-1] ^ tedge_q;
    assign req      = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
    assign wr       = req & wb.wb_we_i;
    assign off      = wb.wb_adr_i[4:0];
    assign glob     = wb.wb_adr_i[8];
    assign en_we    = wr & glob & (wb.wb_adr_i[7:0] == 8'h04) & wb.wb_sel_i[0];

    always_comb begin
        rd_d    = '0;
        hit     = '0;
        ack0    = '0;
        ack1    = '0;
        ctrl_we = '0;
        pend_d  = '0;
        ovr_d   = '0;
        for (int k = 0; k < NUM_BOTS; k++) begin
            hit[k]     = ~glob && (wb.wb_adr_i[7:5] == 3'(k));
            ctrl_we[k] = wr & hit[k] & (off == 5'h04) & wb.wb_sel_i[0];
            ack0[k]    = wr & hit[k] & (off == 5'h0C) & wb.wb_sel_i[0] & wb.wb_dat_i[0];
            ack1[k]    = wr & hit[k] & (off == 5'h0C) & wb.wb_sel_i[0] & wb.wb_dat_i[1];
            // an update landing with an ACK counts as fresh, not as an overrun
            pend_d[k]  = upd_evt[k] | (pend_q[k] & ~ack0[k]);
            ovr_d[k]   = (upd_evt[k] & pend_q[k] & ~ack0[k]) | (ovr_q[k] & ~ack1[k]);
            if (hit[k])
                rd_d = off == 5'h00 ? shadow_q[k] :
                       off == 5'h04 ? {24'h0, ctrl_q[k]} :
                       off == 5'h08 ? {30'h0, ovr_q[k], pend_q[k]} : 32'h0;
        end
        if (glob)
            rd_d = wb.wb_adr_i[7:0] == 8'h00 ? {{(32-NUM_BOTS){1'b0}}, pend_q & irq_en_q} :
                   wb.wb_adr_i[7:0] == 8'h04 ? {{(32-NUM_BOTS){1'b0}}, irq_en_q} :
                   wb.wb_adr_i[7:0] == 8'h08 ? {24'h0, 8'(NUM_BOTS)} : 32'h0;
    end

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            irq_q    <= 1'b0;
            ctrl_q   <= '0;
            irq_en_q <= '0;
            pend_q   <= '0;
            ovr_q    <= '0;
            shadow_q <= '0;
            tsync_q  <= '0;
            tedge_q  <= '0;
        end else begin
            ack_q   <= wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
            if (req) dat_q <= rd_d;
            irq_q   <= |(pend_q & irq_en_q);
            tsync_q <= {tsync_q[SYNC_STAGES-2:0], tog_q};
            tedge_q <= tsync_q[SYNC_STAGES-1];
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            for (int k = 0; k < NUM_BOTS; k++) begin
                if (upd_evt[k]) shadow_q[k] <= hold_q[k];
                if (ctrl_we[k]) ctrl_q[k]   <= wb.wb_dat_i[7:0];
            end
            if (en_we) irq_en_q <= wb.wb_dat_i[NUM_BOTS-1:0];
        end

    assign wb.wb_dat_o = dat_q;
    assign wb.wb_ack_o = ack_q;
    assign wb.wb_err_o = 1'b0;
    assign wb.wb_rty_o = 1'b0;
    assign irq_o       = irq_q;
    assign unused_ok   = ^{wb.wb_adr_i[31:9], wb.wb_sel_i[3:1], wb.wb_dat_i[31:8]};
endmodule

// File: tb/tb_bot_wb_regfile.sv
// tb_bot_wb_regfile: directed plus randomized checks of bot_wb_regfile against a register-level model.
`timescale 1ns/1ps
module tb_bot_wb_regfile;
    localparam int NB = 2;

    logic clk = 1'b0, bot_clk = 1'b0, rstn = 1'b0;
    logic [32*NB-1:0] bot_info = '0;
    logic [NB-1:0]    bot_upd = '0;
    logic [8*NB-1:0]  motctl;
    logic             irq;
    int               n_cmp = 0, n_err = 0;

    logic [7:0]  m_ctrl [NB];
    logic [31:0] m_shadow [NB];
    logic [NB-1:0] m_pend, m_ovr, m_en;

    bot_wb_if wb();

    bot_wb_regfile #(.NUM_BOTS(NB), .SYNC_STAGES(2)) dut (
        .clk(clk), .rstn(rstn), .bot_clk(bot_clk), .wb(wb),
        .bot_info_i(bot_info), .bot_upd_i(bot_upd), .motctl_o(motctl), .irq_o(irq)
    );

    // phases repeat every 70 ns, which makes the CDC latency deterministic when aligned
    always #5 clk = ~clk;
    always #7 bot_clk = ~bot_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void m_reset();
        for (int k = 0; k < NB; k++) begin
            m_ctrl[k] = '0;
            m_shadow[k] = '0;
        end
        m_pend = '0;
        m_ovr = '0;
        m_en = '0;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] adr);
        int k = int'(adr[7:5]);
        if (adr[8])
            return adr[7:0] == 8'h00 ? 32'(m_pend & m_en) :
                   adr[7:0] == 8'h04 ? 32'(m_en) :
                   adr[7:0] == 8'h08 ? 32'(NB) : 32'h0;
        if (k >= NB) return 32'h0;
        case (adr[4:0])
            5'h00:   return m_shadow[k];
            5'h04:   return {24'h0, m_ctrl[k]};
            5'h08:   return {30'h0, m_ovr[k], m_pend[k]};
            default: return 32'h0;
        endcase
    endfunction

    function automatic void m_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        int k = int'(adr[7:5]);
        if (!sel[0]) return;
        if (adr[8]) begin
            if (adr[7:0] == 8'h04) m_en = dat[NB-1:0];
        end else if (k < NB) begin
            if (adr[4:0] == 5'h04) m_ctrl[k] = dat[7:0];
            if (adr[4:0] == 5'h0C) begin
                if (dat[0]) m_pend[k] = 1'b0;
                if (dat[1]) m_ovr[k] = 1'b0;
            end
        end
    endfunction

    function automatic logic [8*NB-1:0] m_motctl();
        logic [8*NB-1:0] v;
        for (int k = 0; k < NB; k++) v[8*k +: 8] = m_ctrl[k];
        return v;
    endfunction

    // called and returns at 1 ns after a clk rising edge
    task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                       output logic [31:0] rd, output int lat, output logic irq_at);
        wb.wb_adr_i = adr;
        wb.wb_dat_i = dat;
        wb.wb_sel_i = sel;
        wb.wb_we_i  = we;
        wb.wb_cyc_i = 1'b1;
        wb.wb_stb_i = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!wb.wb_ack_o && lat < 8);
        rd = wb.wb_dat_o;
        irq_at = irq;
        wb.wb_cyc_i = 1'b0;
        wb.wb_stb_i = 1'b0;
        wb.wb_we_i  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] adr);
        logic [31:0] d;
        int l;
        logic i;
        bus(1'b0, adr, $urandom, 4'hF, d, l, i);
        chk({tag, " ack latency"}, 32'(l), 32'd1);
        chk(tag, d, m_read(adr));
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] d;
        int l;
        logic i;
        bus(1'b1, adr, dat, sel, d, l, i);
        chk("write ack latency", 32'(l), 32'd1);
        m_write(adr, dat, sel);
    endtask

    task automatic settle_mot();
        repeat (3) @(posedge bot_clk);
        @(posedge clk);
        #1;
    endtask

    // pending appears on the 3rd clk edge after the capture edge; with_ack lands an ACK there
    task automatic bot_update(input int k, input logic [31:0] data, input bit with_ack);
        do @(posedge bot_clk); while ($time % 70 != 7);
        #1;
        bot_info[32*k +: 32] = data;
        bot_upd[k] = 1'b1;
        @(posedge bot_clk);
        #1;
        bot_upd[k] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        if (with_ack) wr(32'h0C | (32'(k) << 5), 32'h1, 4'h1);
        else begin
            repeat (3) @(posedge clk);
            #1;
            m_ovr[k] = m_ovr[k] | m_pend[k];
        end
        m_pend[k] = 1'b1;
        m_shadow[k] = data;
    endtask

    function automatic logic [31:0] rand_adr();
        logic [31:0] hi = $urandom & 32'hFFFF_FE00;
        if ($urandom_range(0, 3) == 0) return hi | 32'h100 | (32'($urandom_range(0, 3)) << 2);
        return hi | (32'($urandom_range(0, 3)) << 5) | (32'($urandom_range(0, 4)) << 2);
    endfunction

    initial begin
        logic [31:0] d;
        int l;
        logic i;
        wb.wb_adr_i = '0;
        wb.wb_dat_i = '0;
        wb.wb_sel_i = '0;
        wb.wb_we_i  = 1'b0;
        wb.wb_cyc_i = 1'b0;
        wb.wb_stb_i = 1'b0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset ack", 32'(wb.wb_ack_o), 32'h0);
        chk("reset dat", wb.wb_dat_o, 32'h0);
        chk("reset irq", 32'(irq), 32'h0);
        chk("reset motctl", 32'(motctl), 32'h0);
        rstn = 1'b1;
        repeat (6) @(posedge bot_clk);
        @(posedge clk);
        #1;
        rd_chk("id", 32'h108);
        rd_chk("botctrl0 reset", 32'h04);
        rd_chk("status0 reset", 32'h08);
        rd_chk("irq_status reset", 32'h100);
        chk("err/rty", 32'({wb.wb_err_o, wb.wb_rty_o}), 32'h0);
        chk("irq idle", 32'(irq), 32'h0);

        wr(32'h24, 32'hA5, 4'b0001);
        settle_mot();
        chk("motctl bot1", 32'(motctl), 32'(m_motctl()));
        chk("motctl bot1 byte", 32'(motctl[15:8]), 32'hA5);
        rd_chk("botctrl1", 32'h24);
        wr(32'h24, 32'h5A, 4'b0000);
        settle_mot();
        chk("motctl sel0", 32'(motctl), 32'(m_motctl()));
        rd_chk("botctrl1 sel0", 32'h24);

        wr(32'h104, 32'h1, 4'h1);
        bot_update(0, 32'h11223344, 1'b0);
        rd_chk("status0 pending", 32'h08);
        rd_chk("botinfo0", 32'h00);
        chk("irq pending", 32'(irq), 32'h1);
        rd_chk("irq_status", 32'h100);
        bot_update(0, 32'h55667788, 1'b0);
        rd_chk("status0 overrun", 32'h08);
        bus(1'b1, 32'h0C, 32'h3, 4'h1, d, l, i);
        m_write(32'h0C, 32'h3, 4'h1);
        chk("irq before clear", 32'(i), 32'h1);
        chk("irq after clear", 32'(irq), 32'h0);
        rd_chk("status0 cleared", 32'h08);

        bot_update(0, 32'hCAFE0001, 1'b0);
        rd_chk("status0 pre-coincide", 32'h08);
        bot_update(0, 32'hCAFE0002, 1'b1);
        rd_chk("status0 coincide", 32'h08);
        rd_chk("botinfo0 coincide", 32'h00);

        rd_chk("bot2 read", 32'h40);
        wr(32'h44, 32'hFF, 4'hF);
        wr(32'h4C, 32'h3, 4'hF);
        wr(32'h10, 32'hFF, 4'hF);
        settle_mot();
        chk("motctl oor", 32'(motctl), 32'(m_motctl()));
        for (int a = 0; a < 2*32; a += 4) rd_chk("sweep oor", 32'(a));

        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 4))
                0: rd_chk("rand read", rand_adr());
                1: wr(rand_adr(), $urandom, 4'($urandom));
                2: bot_update($urandom_range(0, NB-1), $urandom, 1'b0);
                3: wr(32'h104, $urandom, 4'($urandom));
                default: begin
                    settle_mot();
                    chk("rand motctl", 32'(motctl), 32'(m_motctl()));
                    chk("rand irq", 32'(irq), 32'(|(m_pend & m_en)));
                end
            endcase
        end
        for (int a = 0; a < 4*32; a += 4) rd_chk("final sweep", 32'(a));
        for (int a = 32'h100; a < 32'h110; a += 4) rd_chk("final global", 32'(a));

        wr(32'h04, 32'h3C, 4'h1);
        settle_mot();
        chk("motctl before reset", 32'(motctl), 32'(m_motctl()));
        wb.wb_adr_i = 32'h04;
        wb.wb_dat_i = 32'h77;
        wb.wb_sel_i = 4'h1;
        wb.wb_we_i  = 1'b1;
        wb.wb_cyc_i = 1'b1;
        wb.wb_stb_i = 1'b1;
        #3 rstn = 1'b0;
        #1;
        m_reset();
        chk("reset mid ack", 32'(wb.wb_ack_o), 32'h0);
        chk("reset mid motctl", 32'(motctl), 32'h0);
        @(posedge clk);
        #1;
        chk("reset mid ack held", 32'(wb.wb_ack_o), 32'h0);
        wb.wb_cyc_i = 1'b0;
        wb.wb_stb_i = 1'b0;
        wb.wb_we_i  = 1'b0;
        rstn = 1'b1;
        repeat (6) @(posedge bot_clk);
        @(posedge clk);
        #1;
        rd_chk("botctrl0 after reset", 32'h04);
        rd_chk("status0 after reset", 32'h08);
        chk("motctl after reset", 32'(motctl), 32'h0);
        chk("irq after reset", 32'(irq), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
